// File: rtl/seq_detect_prog.sv
// Programmable symbol-sequence detector (prefix automaton with overlap control).
// Define SEQ_DETECT_COUNT_EN to add the saturating CNT match counter.
module seq_detect_prog #(
   parameter int                         SYM_W   = 4,
   parameter int                         SEQ_LEN = 6,
   parameter logic [SEQ_LEN*SYM_W-1:0]   PATTERN = 24'h102210,
   parameter int                         CNT_W   = 8,
   localparam int                        LEN_W   = $clog2(SEQ_LEN+1)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [SYM_W-1:0] I,
   input  logic             VALID,
   input  logic             OVL,
   input  logic             CLR,
   output logic             Y,
`ifdef SEQ_DETECT_COUNT_EN
   output logic [LEN_W-1:0] LEN,
   output logic [CNT_W-1:0] CNT
`else
   output logic [LEN_W-1:0] LEN
`endif
);

   function automatic logic [SYM_W-1:0] psym(input int i);
      return PATTERN[(SEQ_LEN-1-i)*SYM_W +: SYM_W];
   endfunction

   // Bit l*SEQ_LEN+m set when the m-symbol prefix is a suffix of the l-symbol prefix.
   function automatic logic [SEQ_LEN*SEQ_LEN-1:0] border_map();
      logic [SEQ_LEN*SEQ_LEN-1:0] m;
      logic                       ok;
      m = '0;
      for (int l = 0; l < SEQ_LEN; l++)
         for (int mm = 0; mm <= l; mm++) begin
            ok = 1'b1;
            for (int t = 0; t < mm; t++)
               if (psym(t) != psym(l-mm+t)) ok = 1'b0;
            m[l*SEQ_LEN+mm] = ok;
         end
      return m;
   endfunction

   function automatic int full_border();
      int  b;
      logic ok;
      b = 0;
      for (int mm = 1; mm < SEQ_LEN; mm++) begin
         ok = 1'b1;
         for (int t = 0; t < mm; t++)
            if (psym(t) != psym(SEQ_LEN-mm+t)) ok = 1'b0;
         if (ok) b = mm;
      end
      return b;
   endfunction

   localparam logic [SEQ_LEN*SEQ_LEN-1:0] BMAP = border_map();
   localparam int                         FBRD = full_border();

   if (SEQ_LEN < 2 || SEQ_LEN > 16 || CNT_W < 1) begin : g_bad_param
      $error("seq_detect_prog: parameter out of range");
   end

   logic [LEN_W-1:0]   len_q, len_d;
   logic               y_d;
   logic [SEQ_LEN-1:0] row;
   logic               match;
   int                 k;

   // The matched-prefix length is the whole history: the longest prefix
   // extendable by I must be a border of the current prefix.
   always_comb begin
      row = '0;
      for (int l = 0; l < SEQ_LEN; l++)
         if (len_q == LEN_W'(l)) row = BMAP[l*SEQ_LEN +: SEQ_LEN];
      k = 0;
      for (int j = 1; j <= SEQ_LEN; j++)
         if (row[j-1] && psym(j-1) == I) k = j;
      match = (k == SEQ_LEN);
      len_d = len_q;
      y_d   = 1'b0;
      if (CLR) begin
         len_d = '0;
      end else if (VALID) begin
         y_d = match;
         if (match) len_d = OVL ? LEN_W'(FBRD) : '0;
         else       len_d = LEN_W'(k);
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         len_q <= '0;
         Y     <= 1'b0;
      end else begin
         len_q <= len_d;
         Y     <= y_d;
      end
   end

   assign LEN = len_q;

`ifdef SEQ_DETECT_COUNT_EN
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)                 CNT <= '0;
      else if (CLR)               CNT <= '0;
      else if (y_d && CNT != '1)  CNT <= CNT + 1'b1;
   end
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Randomized + directed bench for seq_detect_prog against a history-queue model.
module tb_seq_detect_prog;
   localparam int SYM_W   = 4;
   localparam int SEQ_LEN = 6;
   localparam int LEN_W   = 3;
`ifdef SEQ_DETECT_COUNT_EN
   localparam int CNT_W   = 2;
`else
   localparam int CNT_W   = 8;
`endif

   logic             CLK = 1'b0;
   logic             RST_N = 1'b0;
   logic [SYM_W-1:0] I = '0;
   logic             VALID = 1'b0, OVL = 1'b0, CLR = 1'b0;
   logic             Y;
   logic [LEN_W-1:0] LEN;
`ifdef SEQ_DETECT_COUNT_EN
   logic [CNT_W-1:0] CNT;
`endif

   seq_detect_prog #(.SYM_W(SYM_W), .SEQ_LEN(SEQ_LEN), .PATTERN(24'h102210), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST_N(RST_N), .I(I), .VALID(VALID), .OVL(OVL), .CLR(CLR), .Y(Y),
`ifdef SEQ_DETECT_COUNT_EN
      .LEN(LEN), .CNT(CNT)
`else
      .LEN(LEN)
`endif
   );

   always #5 CLK = ~CLK;

   int n_chk = 0, n_pass = 0;
   logic [23:0] pat = 24'h102210;

   // Reference: the accepted-symbol history, searched directly for prefix matches.
   int   hist[$];
   logic m_y = 1'b0;
   int   m_len = 0, m_cnt = 0;

   function automatic int psym(input int i);
      return int'(pat[(SEQ_LEN-1-i)*SYM_W +: SYM_W]);
   endfunction

   function automatic int suffix_match(input int limit);
      int best = 0;
      for (int j = 1; j <= limit && j <= hist.size(); j++) begin
         bit ok = 1;
         for (int t = 0; t < j; t++)
            if (hist[hist.size()-j+t] != psym(t)) ok = 0;
         if (ok) best = j;
      end
      return best;
   endfunction

   task automatic model_reset();
      hist.delete(); m_y = 0; m_len = 0; m_cnt = 0;
   endtask

   task automatic model_edge();
      int k;
      if (CLR) model_reset();
      else if (VALID) begin
         hist.push_back(int'(I));
         k = suffix_match(SEQ_LEN);
         if (k == SEQ_LEN) begin
            m_y = 1;
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (OVL) m_len = suffix_match(SEQ_LEN-1);
            else begin hist.delete(); m_len = 0; end
         end else begin
            m_y = 0; m_len = k;
         end
         if (hist.size() > SEQ_LEN) void'(hist.pop_front());
      end else m_y = 0;
   endtask

   task automatic tick(input logic [SYM_W-1:0] i, input logic v, input logic o, input logic c);
      I = i; VALID = v; OVL = o; CLR = c;
      @(posedge CLK);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      RST_N = 0;
      for (int n = 0; n < 8; n++) begin
         I = (n % 2 == 0) ? 4'd1 : 4'd0; VALID = 1; OVL = 1; CLR = 0;
         @(posedge CLK); #1;
         n_chk++; if (Y !== 1'b0 || LEN !== 3'd0) $display("FAIL reset_hold n=%0d Y=%b LEN=%0d want Y=0 LEN=0", n, Y, LEN); else n_pass++;
      end
      RST_N = 1; model_reset();
      tick(1, 1, 1, 0); tick(0, 1, 1, 0); tick(2, 1, 1, 0);
      n_chk++; if (LEN !== 3'd3) $display("FAIL pre_reset_len got %0d want 3", LEN); else n_pass++;
      #2 RST_N = 0; #1;
      n_chk++; if (LEN !== 3'd0) $display("FAIL async_reset_len got %0d want 0", LEN); else n_pass++;
      #3 RST_N = 1; model_reset();
      tick(2, 1, 1, 0); tick(1, 1, 1, 0); tick(0, 1, 1, 0);
      n_chk++; if (Y !== 1'b0 || Y !== m_y) $display("FAIL reset_no_carry Y=%b want 0", Y); else n_pass++;
      n_chk++; if (LEN !== 3'(m_len)) $display("FAIL reset_restart_len got %0d want %0d", LEN, m_len); else n_pass++;
   endtask

   task automatic test_basic();
      int s[6] = '{1, 0, 2, 2, 1, 0};
      tick(0, 0, 1, 1);
      for (int n = 0; n < 6; n++) begin
         tick(4'(s[n]), 1, 1, 0);
         n_chk++; if (Y !== (n == 5) || Y !== m_y) $display("FAIL basic_y edge=%0d Y=%b want %b", n+1, Y, n == 5); else n_pass++;
      end
      n_chk++; if (LEN !== 3'd2 || LEN !== 3'(m_len)) $display("FAIL basic_len_after got %0d want 2", LEN); else n_pass++;
   endtask

   task automatic test_overlap();
      int s[10] = '{1, 0, 2, 2, 1, 0, 2, 2, 1, 0};
      for (int o = 0; o < 2; o++) begin
         tick(0, 0, 0, 1);
         for (int n = 0; n < 10; n++) begin
            logic exp_y;
            exp_y = (n == 5) || (o == 1 && n == 9);
            tick(4'(s[n]), 1, 1'(o), 0);
            n_chk++; if (Y !== exp_y || Y !== m_y) $display("FAIL overlap_y ovl=%0d edge=%0d Y=%b want %b", o, n+1, Y, exp_y); else n_pass++;
         end
      end
   endtask

   task automatic test_prefix_restart();
      int s[7] = '{1, 1, 0, 2, 2, 1, 0};
      tick(0, 0, 0, 1);
      for (int n = 0; n < 7; n++) begin
         tick(4'(s[n]), 1, 1, 0);
         n_chk++; if (Y !== (n == 6) || LEN !== 3'(m_len)) $display("FAIL restart edge=%0d Y=%b LEN=%0d want Y=%b LEN=%0d", n+1, Y, LEN, n == 6, m_len); else n_pass++;
         if (n == 1) begin
            n_chk++; if (LEN !== 3'd1) $display("FAIL restart_len1 got %0d want 1", LEN); else n_pass++;
         end
      end
   endtask

   task automatic test_idle();
      int s[6] = '{1, 0, 2, 2, 1, 0};
      logic [LEN_W-1:0] held;
      tick(0, 0, 1, 1);
      for (int n = 0; n < 6; n++) begin
         tick(4'(s[n]), 1, 1, 0);
         n_chk++; if (Y !== (n == 5)) $display("FAIL idle_y_valid edge=%0d Y=%b want %b", n+1, Y, n == 5); else n_pass++;
         held = LEN;
         tick(7, 0, 1, 0);
         n_chk++; if (Y !== 1'b0 || LEN !== held || LEN !== 3'(m_len)) $display("FAIL idle_hold n=%0d Y=%b LEN=%0d want Y=0 LEN=%0d", n, Y, LEN, m_len); else n_pass++;
      end
   endtask

   task automatic test_clr();
      tick(0, 0, 0, 1);
      tick(1, 1, 0, 0); tick(0, 1, 0, 0); tick(2, 1, 0, 0); tick(2, 1, 0, 0); tick(1, 1, 0, 0);
      tick(0, 1, 0, 1);
      n_chk++; if (Y !== 1'b0 || LEN !== 3'd0) $display("FAIL clr_priority Y=%b LEN=%0d want Y=0 LEN=0", Y, LEN); else n_pass++;
   endtask

`ifdef SEQ_DETECT_COUNT_EN
   task automatic test_count();
      int s[6] = '{1, 0, 2, 2, 1, 0};
      tick(0, 0, 0, 1);
      for (int m = 1; m <= 5; m++) begin
         for (int n = 0; n < 6; n++) tick(4'(s[n]), 1, 0, 0);
         n_chk++; if (CNT !== 2'(m > 3 ? 3 : m)) $display("FAIL count_sat m=%0d got %0d want %0d", m, CNT, m > 3 ? 3 : m); else n_pass++;
      end
      tick(1, 1, 0, 0); tick(0, 1, 0, 0); tick(2, 1, 0, 0);
      tick(2, 1, 0, 1);
      n_chk++; if (CNT !== 2'd0 || LEN !== 3'd0 || Y !== 1'b0) $display("FAIL count_clr CNT=%0d LEN=%0d Y=%b want 0 0 0", CNT, LEN, Y); else n_pass++;
   endtask
`endif

   task automatic test_random();
      tick(0, 0, 0, 1);
      for (int n = 0; n < 3000; n++) begin
         tick(4'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0);
         n_chk++; if (Y !== m_y) $display("FAIL rand_y cyc=%0d Y=%b want %b", n, Y, m_y); else n_pass++;
         n_chk++; if (LEN !== 3'(m_len)) $display("FAIL rand_len cyc=%0d got %0d want %0d", n, LEN, m_len); else n_pass++;
`ifdef SEQ_DETECT_COUNT_EN
         n_chk++; if (CNT !== 2'(m_cnt)) $display("FAIL rand_cnt cyc=%0d got %0d want %0d", n, CNT, m_cnt); else n_pass++;
`endif
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overlap();
      test_prefix_restart();
      test_idle();
      test_clr();
`ifdef SEQ_DETECT_COUNT_EN
      test_count();
`endif
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
